res_uart_reporter: RTL and testbench
====================================

Name: res_uart_reporter

Overview:
- Downstream consumer of the RC resistance meter's BCD result; serialises each completed measurement as an ASCII line over a UART TX pin.
- Sits after the binary-to-BCD converter, alongside the seven-segment path, and drives a spare TinyTapeout output.
- Line format: NUM_DIGITS characters, most significant digit first, then CR (0x0D) and LF (0x0A); 8N1, LSB first.
- One-entry pending buffer, so a new result arriving mid-transmission is never lost; only older unsent results are overwritten.

Parameters:
- CLK_HZ, 50000000: system clock frequency in Hz.
- BAUD, 115200: line rate. Bit period DIV = (CLK_HZ + BAUD/2) / BAUD, giving 434 at the defaults.
- NUM_DIGITS, 6: number of BCD digits per line.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- bcd_in  input  4*NUM_DIGITS  BCD digits; bits [4*NUM_DIGITS-1 -: 4] are the most significant digit.
- bcd_valid  input  1  one-cycle strobe; bcd_in and overflow_in are valid in this cycle.
- overflow_in  input  1  the measurement overflowed; the line is printed as dashes.
- tx  output  1  UART serial out, idle high.
- busy  output  1  high while a line is being transmitted.
- pending  output  1  a captured line is waiting in the buffer.
- dropped  output  1  sticky; set when a pending entry is overwritten, cleared only by reset.

Behaviour:
- Reset values (applied asynchronously): tx=1, busy=0, pending=0, dropped=0; FSM in IDLE; all counters 0.
- Reset asserted mid-frame: tx returns to 1 immediately, and the partially sent line is abandoned.
- Capture, bcd_valid while IDLE with no pending entry:
  - Latch digits and overflow into the shift buffer.
  - busy=1 from the next cycle; the START bit (tx=0) also begins in that next cycle.
- Capture, bcd_valid while busy:
  - Store in the pending register and set pending=1.
  - If pending was already 1, overwrite the entry and set dropped=1.
- Line complete (final STOP bit of LF finishes):
  - If pending=1: load the pending entry, clear pending, and start the next START bit in the following cycle; busy stays 1.
  - Otherwise return to IDLE with busy=0.
- bcd_valid in the same cycle as line completion: the new value is loaded directly, bypassing pending, and dropped is not set.
- FSM states: IDLE -> START -> DATA -> STOP.
  - START, each DATA bit and STOP each last exactly DIV cycles.
  - DATA has 8 bits, LSB first.
  - STOP -> START while bytes remain in the line; otherwise -> IDLE, or to the next line as above.
- Byte index runs 0..NUM_DIGITS+1:
  - Index k < NUM_DIGITS: character for digit k, MSD first.
  - Then 0x0D, then 0x0A.
- Character mapping:
  - Digit d in 0..9: 0x30+d.
  - Digit > 9 (invalid BCD): '?' (0x3F).
  - overflow latched: every digit position sends '-' (0x2D).
- Widths:
  - Bit-period counter: $clog2(DIV) bits; wraps to 0 at DIV-1.
  - Byte index: $clog2(NUM_DIGITS+2) bits.
- Line duration: (NUM_DIGITS+2)*10*DIV cycles, i.e. 34720 cycles at the defaults.
- tx is driven from a register, never combinationally.

Optional Feature:
- Macro: RES_UART_LEADING_ZERO_BLANK_EN.
- Defined: leading zero digits are sent as space (0x20). The least significant digit is always sent as a digit, so an all-zero value prints "     0". Blanking stops at the first non-zero digit. Overflow lines are unaffected.
- Undefined: all digits are sent as 0x30+d, so zero prints "000000".

Decomposition:
- Shared package res_meter_pkg:
  - ASCII constants ASCII_ZERO, ASCII_CR, ASCII_LF, ASCII_DASH, ASCII_QMARK, ASCII_SPACE.
  - A function computing DIV from CLK_HZ and BAUD.
  - The FSM state typedef.
- One sub-module, uart_tx_byte:
  - Owns the START/DATA/STOP timing for a single byte.
  - Handshake: start/byte_in in, done pulse out, tx out.
  - The parent owns line sequencing, the pending buffer and character mapping.

Test Plan:
- All tests run at CLK_HZ=1000, BAUD=100, so DIV=10.
- Reset: tx=1, busy=0, pending=0, dropped=0; reset asserted at cycle 37 of a frame -> tx=1 in the same cycle and busy=0.
- Basic line: bcd_in=0x123456 with a bcd_valid pulse -> busy rises on the next cycle; decoded bytes are 31 32 33 34 35 36 0D 0A; busy falls after exactly 800 cycles.
- Overflow: overflow_in=1 with bcd_in=0x000000 -> decoded bytes 2D x6, then 0D 0A.
- Invalid BCD: bcd_in=0x00A009 -> decoded bytes 30 30 3F 30 30 39 0D 0A.
- Buffering:
  - Send 0x000001, then strobe 0x000002 at cycle 100 and 0x000003 at cycle 200 -> dropped=1; second line is "000003\r\n".
  - A strobe in the exact completion cycle is sent next with dropped still 0.
- Feature on: bcd_in=0x000000 -> decoded bytes 20 20 20 20 20 30 0D 0A; bcd_in=0x010203 -> 20 31 30 32 30 33.

Source files
------------

// File: rtl/res_meter_pkg.sv
// ----------------------------------------------------------------------------
// res_meter_pkg
//   Shared definitions for the RC resistance meter UART reporting path:
//   ASCII character constants, the UART bit-period helper, the transmitter
//   FSM state encoding and a BCD-digit-to-ASCII helper.
// ----------------------------------------------------------------------------
package res_meter_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // Byte transmitter FSM. Plain vector constants keep the encoding visible
    // to tools and older flows that do not handle enums well.
    typedef logic [1:0] tx_state_t;
    localparam tx_state_t ST_IDLE  = 2'd0;
    localparam tx_state_t ST_START = 2'd1;
    localparam tx_state_t ST_DATA  = 2'd2;
    localparam tx_state_t ST_STOP  = 2'd3;

    // Bit period in clock cycles, rounded to the nearest integer.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    // One BCD digit to its ASCII character; anything above 9 becomes '?'.
    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return (d > 4'd9) ? ASCII_QMARK : (ASCII_ZERO + {4'h0, d});
    endfunction

endpackage

// File: rtl/res_uart_reporter_tx_byte.sv
// ----------------------------------------------------------------------------
// uart_tx_byte
//   Sends one 8N1 byte, LSB first. START, each DATA bit and STOP last exactly
//   DIV cycles. A new start may be accepted while idle or in the final cycle
//   of STOP (the cycle in which done pulses), so back-to-back bytes leave no
//   idle gap on the line.
//
//   Ports:
//     clk      in   system clock, rising edge
//     reset    in   asynchronous, active-high reset
//     start    in   begin a byte; the START bit appears from the next cycle
//     byte_in  in   byte to send, sampled when start is accepted
//     done     out  high during the last cycle of the STOP bit
//     tx       out  serial line, idle high, registered
// ----------------------------------------------------------------------------
module uart_tx_byte
    import res_meter_pkg::*;
#(
    parameter int DIV = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       done,
    output logic       tx
);

    localparam int             CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);

    tx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [2:0]    bit_q,   bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q,    tx_d;

    logic period_end;
    assign period_end = (cnt_q == CNT_MAX);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = (state_q == ST_IDLE || period_end) ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_START;
                    shift_d = byte_in;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (period_end) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end
            ST_DATA: begin
                if (period_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
            default: begin // ST_STOP
                if (period_end) begin
                    done = 1'b1;
                    if (start) begin
                        state_d = ST_START;
                        shift_d = byte_in;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/res_uart_reporter.sv
// ----------------------------------------------------------------------------
// res_uart_reporter
//   Serialises each completed BCD measurement as an ASCII line:
//   NUM_DIGITS characters (MSD first), CR, LF; 8N1 at BAUD.
//   A one-entry pending buffer holds a result that arrives mid-line; if a
//   second one arrives before it is sent, it is overwritten and the sticky
//   dropped flag is set.
//
//   Optional build macro RES_UART_LEADING_ZERO_BLANK_EN: leading zero digits
//   are sent as spaces (the least significant digit always prints).
//
//   Ports:
//     clk          in   system clock, rising edge
//     reset        in   asynchronous, active-high reset
//     bcd_in       in   NUM_DIGITS BCD digits, MSD in the top nibble
//     bcd_valid    in   one-cycle strobe qualifying bcd_in / overflow_in
//     overflow_in  in   measurement overflowed; digits print as '-'
//     tx           out  UART serial out, idle high
//     busy         out  a line is being transmitted
//     pending      out  a captured line waits in the buffer
//     dropped      out  sticky: a pending entry was overwritten
// ----------------------------------------------------------------------------
module res_uart_reporter
    import res_meter_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int NUM_DIGITS = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    bcd_valid,
    input  logic                    overflow_in,
    output logic                    tx,
    output logic                    busy,
    output logic                    pending,
    output logic                    dropped
);

    localparam int             DIV      = calc_div(CLK_HZ, BAUD);
    localparam int             DW       = 4 * NUM_DIGITS;
    localparam int             IW       = $clog2(NUM_DIGITS + 2);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_DIGITS + 1);

    // Character for byte position idx of a line: digits, then CR, then LF.
    function automatic logic [7:0] char_for(input logic [DW-1:0] digits,
                                            input logic          ovf,
                                            input logic [IW-1:0] idx);
        logic [7:0] c;
        logic [3:0] dig;
`ifdef RES_UART_LEADING_ZERO_BLANK_EN
        logic       lead;
`endif
        c   = ASCII_LF;
        dig = '0;
        if (int'(idx) < NUM_DIGITS) begin
            dig = 4'(digits >> (4 * (NUM_DIGITS - 1 - int'(idx))));
            c   = ovf ? ASCII_DASH : digit_char(dig);
`ifdef RES_UART_LEADING_ZERO_BLANK_EN
            // Blank while this digit and all more significant ones are zero;
            // the last digit always prints so zero reads as "     0".
            lead = 1'b1;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (k <= int'(idx) && 4'(digits >> (4 * (NUM_DIGITS - 1 - k))) != 4'd0)
                    lead = 1'b0;
            end
            if (!ovf && lead && int'(idx) != NUM_DIGITS - 1)
                c = ASCII_SPACE;
`endif
        end else if (int'(idx) == NUM_DIGITS) begin
            c = ASCII_CR;
        end
        return c;
    endfunction

    logic          busy_q,      busy_d;
    logic [IW-1:0] idx_q,       idx_d;
    logic [DW-1:0] line_q,      line_d;
    logic          ovf_q,       ovf_d;
    logic          pend_q,      pend_d;
    logic [DW-1:0] pend_line_q, pend_line_d;
    logic          pend_ovf_q,  pend_ovf_d;
    logic          dropped_q,   dropped_d;

    logic       byte_done;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       line_end;

    assign line_end = busy_q && byte_done && (idx_q == LAST_IDX);

    always_comb begin
        busy_d      = busy_q;
        idx_d       = idx_q;
        line_d      = line_q;
        ovf_d       = ovf_q;
        pend_d      = pend_q;
        pend_line_d = pend_line_q;
        pend_ovf_d  = pend_ovf_q;
        dropped_d   = dropped_q;
        tx_start    = 1'b0;

        // Line sequencing. A start is issued in the same cycle the previous
        // byte reports done, so bytes and lines follow without gaps.
        if (!busy_q) begin
            if (bcd_valid) begin
                busy_d   = 1'b1;
                idx_d    = '0;
                line_d   = bcd_in;
                ovf_d    = overflow_in;
                tx_start = 1'b1;
            end
        end else if (byte_done) begin
            tx_start = 1'b1;
            if (idx_q != LAST_IDX) begin
                idx_d = idx_q + 1'b1;
            end else begin
                idx_d = '0;
                if (pend_q) begin
                    line_d = pend_line_q;
                    ovf_d  = pend_ovf_q;
                    pend_d = 1'b0;
                end else if (bcd_valid) begin
                    line_d = bcd_in;
                    ovf_d  = overflow_in;
                end else begin
                    busy_d   = 1'b0;
                    tx_start = 1'b0;
                end
            end
        end

        // Pending buffer. A strobe at line end with an empty buffer is sent
        // directly above. With a full buffer at line end, the older entry is
        // sent first and the new one takes its freed slot, so nothing is lost
        // and dropped stays clear.
        if (busy_q && bcd_valid && !(line_end && !pend_q)) begin
            pend_line_d = bcd_in;
            pend_ovf_d  = overflow_in;
            pend_d      = 1'b1;
            if (pend_q && !line_end)
                dropped_d = 1'b1;
        end
    end

    // Character for the byte being started, taken from the next-state line so
    // the first byte of a freshly captured value is correct.
    assign tx_byte = char_for(line_d, ovf_d, idx_d);

    // NOTE: the line and pending payload registers are small flops, not a
    // memory array, so they are reset along with the control state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q      <= 1'b0;
            idx_q       <= '0;
            line_q      <= '0;
            ovf_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_line_q <= '0;
            pend_ovf_q  <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            idx_q       <= idx_d;
            line_q      <= line_d;
            ovf_q       <= ovf_d;
            pend_q      <= pend_d;
            pend_line_q <= pend_line_d;
            pend_ovf_q  <= pend_ovf_d;
            dropped_q   <= dropped_d;
        end
    end

    uart_tx_byte #(
        .DIV (DIV)
    ) u_tx_byte (
        .clk     (clk),
        .reset   (reset),
        .start   (tx_start),
        .byte_in (tx_byte),
        .done    (byte_done),
        .tx      (tx)
    );

    assign busy    = busy_q;
    assign pending = pend_q;
    assign dropped = dropped_q;

endmodule

// File: tb/tb_res_uart_reporter.sv
// ----------------------------------------------------------------------------
// tb_res_uart_reporter
//   Self-checking bench at CLK_HZ=1000, BAUD=100 (DIV=10). A UART receiver
//   decodes tx and compares each byte against a scoreboard queue filled when
//   the stimulus is driven. Table-driven lines plus hand-written sequences for
//   timing, buffering, completion-cycle strobes and reset mid-frame.
// ----------------------------------------------------------------------------
module tb_res_uart_reporter;

    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 100;
    localparam int ND     = 6;
    localparam int DIV    = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4*ND-1:0] bcd_in = '0;
    logic          bcd_valid = 1'b0;
    logic          overflow_in = 1'b0;
    logic          tx, busy, pending, dropped;

    always #5 clk = ~clk;

    res_uart_reporter #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .NUM_DIGITS (ND)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bcd_in      (bcd_in),
        .bcd_valid   (bcd_valid),
        .overflow_in (overflow_in),
        .tx          (tx),
        .busy        (busy),
        .pending     (pending),
        .dropped     (dropped)
    );

    int         n_pass  = 0;
    int         n_total = 0;
    logic [7:0] exp_q[$];
    bit         decoder_en = 1'b1;

    typedef struct {
        logic [23:0] bcd;
        logic        ovf;
        logic [47:0] text;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_line(input logic [47:0] text);
        for (int k = 0; k < ND; k++) exp_q.push_back(8'(text >> (8 * (ND - 1 - k))));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Called at a falling edge; the strobe is sampled at the next rising edge
    // and the task returns half a cycle after it.
    task automatic strobe(input logic [23:0] v, input logic ovf);
        bcd_in      = v;
        overflow_in = ovf;
        bcd_valid   = 1'b1;
        @(negedge clk);
        bcd_valid   = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, 1'b0);
    endtask

    // UART receiver: samples each bit at its centre.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (decoder_en && !reset && tx === 1'b0) begin
                repeat (DIV / 2 - 1) @(negedge clk);
                check("start_bit_mid", tx, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = tx;
                end
                repeat (DIV) @(negedge clk);
                check("stop_bit", tx, 1'b1);
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_byte: got 0x%02h, expected no byte at %0t", b, $time);
                end else begin
                    check("rx_byte", b, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  stayed_idle;

        vecs[0] = '{24'h123456, 1'b0, "123456"};
        vecs[1] = '{24'h000000, 1'b1, "------"};
        vecs[5] = '{24'h999999, 1'b0, "999999"};
`ifdef RES_UART_LEADING_ZERO_BLANK_EN
        vecs[2] = '{24'h00A009, 1'b0, "  ?009"};
        vecs[3] = '{24'h000000, 1'b0, "     0"};
        vecs[4] = '{24'h010203, 1'b0, " 10203"};
        vecs[6] = '{24'h0F0000, 1'b0, " ?0000"};
`else
        vecs[2] = '{24'h00A009, 1'b0, "00?009"};
        vecs[3] = '{24'h000000, 1'b0, "000000"};
        vecs[4] = '{24'h010203, 1'b0, "010203"};
        vecs[6] = '{24'h0F0000, 1'b0, "0?0000"};
`endif

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_pending", pending, 1'b0);
        check("reset_dropped", dropped, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Basic line with exact timing.
        push_line("123456");
        strobe(24'h123456, 1'b0);
        check("busy_rise", busy, 1'b1);
        check("first_start_bit", tx, 1'b0);
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("line_cycles", n, 800);
        repeat (5) @(negedge clk);
        check("basic_drained", exp_q.size(), 0);

        // Table of lines.
        for (int i = 0; i < 7; i++) begin
            push_line(vecs[i].text);
            strobe(vecs[i].bcd, vecs[i].ovf);
            wait_idle(1000, "table_line_done");
            repeat (5) @(negedge clk);
            check("table_drained", exp_q.size(), 0);
            check("table_pending", pending, 1'b0);
        end
        check("table_dropped", dropped, 1'b0);

        // Buffering: second strobe is overwritten by the third.
        push_line("100001");
        strobe(24'h100001, 1'b0);
        repeat (99) @(negedge clk);
        strobe(24'h200002, 1'b0);
        check("pend_after_2nd", pending, 1'b1);
        check("drop_after_2nd", dropped, 1'b0);
        repeat (99) @(negedge clk);
        strobe(24'h300003, 1'b0);
        check("pend_after_3rd", pending, 1'b1);
        check("drop_after_3rd", dropped, 1'b1);
        push_line("300003");
        wait_idle(2000, "buffered_done");
        repeat (5) @(negedge clk);
        check("buffered_drained", exp_q.size(), 0);
        check("buffered_pending", pending, 1'b0);
        check("dropped_sticky", dropped, 1'b1);

        // Reset clears the sticky flag.
        reset = 1'b1;
        @(negedge clk);
        check("dropped_cleared", dropped, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Strobe exactly in the completion cycle.
        push_line("400004");
        strobe(24'h400004, 1'b0);
        repeat (799) @(negedge clk);
        check("end_busy_before", busy, 1'b1);
        check("end_in_stop", tx, 1'b1);
        push_line("500005");
        strobe(24'h500005, 1'b0);
        check("end_busy_after", busy, 1'b1);
        check("end_next_start", tx, 1'b0);
        check("end_pending", pending, 1'b0);
        check("end_dropped", dropped, 1'b0);
        wait_idle(1000, "end_line_done");
        repeat (5) @(negedge clk);
        check("end_drained", exp_q.size(), 0);
        check("end_dropped_final", dropped, 1'b0);

        // Reset at cycle 37 of a frame (inside data bit 2, which is 0).
        decoder_en = 1'b0;
        strobe(24'h000000, 1'b0);
        repeat (37) @(negedge clk);
        check("pre_reset_tx", tx, 1'b0);
        #1 reset = 1'b1;
        #1;
        check("midreset_tx", tx, 1'b1);
        check("midreset_busy", busy, 1'b0);
        check("midreset_pending", pending, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        stayed_idle = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) stayed_idle = 1'b0;
        end
        check("abandoned_line", stayed_idle, 1'b1);
        decoder_en = 1'b1;

        // Recovery after reset.
        push_line("987654");
        strobe(24'h987654, 1'b0);
        wait_idle(1000, "recover_done");
        repeat (5) @(negedge clk);
        check("recover_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
